// File: rtl/aes128_kexp_invsbox_if.sv
// aes128_kexp_invsbox_if
//   Groups the key-schedule load/output signals and the inverse S-box
//   lookup port of aes128_kexp_invsbox.
//   kld    : key load strobe (master -> slave)
//   key    : 128-bit cipher key, word0 = key[127:96] (master -> slave)
//   wo_0..3: registered round-key words (slave -> master)
//   isb_a  : inverse S-box input byte (master -> slave)
//   isb_d  : InvSbox(isb_a), combinational (slave -> master)
interface aes128_kexp_invsbox_if;
   logic         kld;
   logic [127:0] key;
   logic [31:0]  wo_0;
   logic [31:0]  wo_1;
   logic [31:0]  wo_2;
   logic [31:0]  wo_3;
   logic [7:0]   isb_a;
   logic [7:0]   isb_d;

   modport master (
      output kld, key, isb_a,
      input  wo_0, wo_1, wo_2, wo_3, isb_d
   );

   modport slave (
      input  kld, key, isb_a,
      output wo_0, wo_1, wo_2, wo_3, isb_d
   );
endinterface

// File: rtl/aes128_kexp_invsbox.sv
// aes128_kexp_invsbox
//   AES-128 key-schedule generator for the decryptor key buffer, plus a
//   standalone combinational inverse S-box.
//   After a kld edge, round key r (r = 0..10) appears on wo_0..wo_3 for one
//   cycle, r+1 edges counting the load edge as the first. After round 10 the
//   schedule free-runs with rcon = 0 and its outputs carry no meaning.
//   Ports:
//     clk : rising-edge clock
//     rst : synchronous active-high reset, priority over kld
//     bus : slave side of aes128_kexp_invsbox_if (kld/key/wo_*/isb_a/isb_d)
//   S-boxes are built from GF(2^8) inversion (poly 0x11B) and the FIPS-197
//   affine transforms, so no table ROMs are needed.
module aes128_kexp_invsbox (
   input  logic                   clk,
   input  logic                   rst,
   aes128_kexp_invsbox_if.slave   bus
);

   localparam logic [3:0]  LAST_ROUND = 4'd10;
   localparam logic [31:0] RCON_FIRST = 32'h0100_0000;

   // GF(2^8) multiply, reduction by x^8 + x^4 + x^3 + x + 1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // a^254 = a^-1 for a != 0, and 0 for a == 0
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = gf_mul(a, a);
      acc = sq;
      for (int i = 1; i < 7; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] rotl1(input logic [7:0] x);
      return {x[6:0], x[7]};
   endfunction

   function automatic logic [7:0] rotl2(input logic [7:0] x);
      return {x[5:0], x[7:6]};
   endfunction

   function automatic logic [7:0] rotl3(input logic [7:0] x);
      return {x[4:0], x[7:5]};
   endfunction

   function automatic logic [7:0] rotl4(input logic [7:0] x);
      return {x[3:0], x[7:4]};
   endfunction

   function automatic logic [7:0] rotl6(input logic [7:0] x);
      return {x[1:0], x[7:2]};
   endfunction

   function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
      logic [7:0] x;
      x = gf_inv(a);
      return x ^ rotl1(x) ^ rotl2(x) ^ rotl3(x) ^ rotl4(x) ^ 8'h63;
   endfunction

   function automatic logic [7:0] sbox_inv(input logic [7:0] a);
      logic [7:0] x;
      x = rotl1(a) ^ rotl3(a) ^ rotl6(a) ^ 8'h05;
      return gf_inv(x);
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   logic [31:0] w0_q, w1_q, w2_q, w3_q;
   logic [31:0] w0_d, w1_d, w2_d, w3_d;
   logic [31:0] rcon_q, rcon_d;
   logic [3:0]  round_q, round_d;

   logic [31:0] rot_w;
   logic [31:0] sub_w;
   logic [31:0] t_w;
   logic [31:0] n0, n1, n2, n3;

   always_comb begin
      rot_w = {w3_q[23:0], w3_q[31:24]};
      sub_w = {sbox_fwd(rot_w[31:24]), sbox_fwd(rot_w[23:16]),
               sbox_fwd(rot_w[15:8]),  sbox_fwd(rot_w[7:0])};
      t_w   = sub_w ^ rcon_q;
      n0    = w0_q ^ t_w;
      n1    = n0 ^ w1_q;
      n2    = n1 ^ w2_q;
      n3    = n2 ^ w3_q;
   end

   always_comb begin
      w0_d    = n0;
      w1_d    = n1;
      w2_d    = n2;
      w3_d    = n3;
      round_d = (round_q >= LAST_ROUND) ? LAST_ROUND : round_q + 4'd1;
      // rcon used while producing round 10 is 0x36; beyond that it stays 0
      if (round_q >= LAST_ROUND - 4'd1) begin
         rcon_d = 32'h0;
      end else begin
         rcon_d = {xtime(rcon_q[31:24]), 24'h0};
      end

      if (rst) begin
         w0_d    = 32'h0;
         w1_d    = 32'h0;
         w2_d    = 32'h0;
         w3_d    = 32'h0;
         round_d = 4'd0;
         rcon_d  = 32'h0;
      end else if (bus.kld) begin
         w0_d    = bus.key[127:96];
         w1_d    = bus.key[95:64];
         w2_d    = bus.key[63:32];
         w3_d    = bus.key[31:0];
         round_d = 4'd0;
         rcon_d  = RCON_FIRST;
      end
   end

   always_ff @(posedge clk) begin
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      w3_q    <= w3_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
   end

   assign bus.wo_0  = w0_q;
   assign bus.wo_1  = w1_q;
   assign bus.wo_2  = w2_q;
   assign bus.wo_3  = w3_q;
   assign bus.isb_d = sbox_inv(bus.isb_a);

endmodule

// File: tb/tb_aes128_kexp_invsbox.sv
module tb_aes128_kexp_invsbox;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   aes128_kexp_invsbox_if bus ();

   aes128_kexp_invsbox dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

   localparam logic [127:0] RK_A [0:10] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
   };

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // compares all four round-key words against a 128-bit expectation
   task automatic check_rk(input string tag, input logic [127:0] exp);
      logic [127:0] obs;
      obs = {bus.wo_0, bus.wo_1, bus.wo_2, bus.wo_3};
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%032h expected=%032h", tag, obs, exp);
      end
   endtask

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [7:0] a;
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      bus.kld   = 1'b0;
      bus.key   = '0;
      bus.isb_a = 8'h00;

      // reset, two cycles
      step();
      step();
      check_rk("reset_zero", 128'h0);

      // kld with rst: rst wins
      bus.kld = 1'b1;
      bus.key = KEY_A;
      step();
      check_rk("reset_over_kld", 128'h0);

      // release with kld=0: free-run from zero words with rcon=0
      rst     = 1'b0;
      bus.kld = 1'b0;
      step();
      check_rk("freerun_from_reset_1", {4{32'h63636363}});
      step();
      check_rk("freerun_from_reset_2", {2{32'h98989898, 32'hfbfbfbfb}});

      // full schedule for FIPS-197 A.1 key
      bus.kld = 1'b1;
      bus.key = KEY_A;
      step();
      bus.kld = 1'b0;
      bus.key = '0;
      check_rk("key_a_round_0", RK_A[0]);
      for (int r = 1; r <= 10; r++) begin
         step();
         check_rk($sformatf("key_a_round_%0d", r), RK_A[r]);
      end

      // reload mid-schedule with a different key
      bus.kld = 1'b1;
      bus.key = KEY_A;
      step();
      bus.kld = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check_rk("key_a_round_4_before_reload", RK_A[4]);
      bus.kld = 1'b1;
      bus.key = KEY_B;
      step();
      bus.kld = 1'b0;
      bus.key = '0;
      check_rk("key_b_round_0", KEY_B);
      step();
      check_rk("key_b_round_1", 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
      for (int r = 2; r <= 10; r++) step();
      check_rk("key_b_round_10", 128'h13111d7fe3944a17f307a78b4d2b30c5);

      // rst mid-expansion
      bus.kld = 1'b1;
      bus.key = KEY_A;
      step();
      bus.kld = 1'b0;
      step();
      step();
      check_rk("key_a_round_2_before_rst", RK_A[2]);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_rk("rst_mid_expansion", 128'h0);

      // inverse S-box spot checks
      bus.isb_a = 8'h00; #1; check8("isb_00", bus.isb_d, 8'h52);
      bus.isb_a = 8'h01; #1; check8("isb_01", bus.isb_d, 8'h09);
      bus.isb_a = 8'h63; #1; check8("isb_63", bus.isb_d, 8'h00);
      bus.isb_a = 8'h7c; #1; check8("isb_7c", bus.isb_d, 8'h01);
      bus.isb_a = 8'h16; #1; check8("isb_16", bus.isb_d, 8'hff);
      bus.isb_a = 8'hff; #1; check8("isb_ff", bus.isb_d, 8'h7d);

      // exhaustive: InvSbox(Sbox(x)) == x for every byte
      for (int x = 0; x < 256; x++) begin
         a = x[7:0];
         bus.isb_a = SBOX[x];
         #1;
         check8($sformatf("isb_of_sbox_%02h", a), bus.isb_d, a);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
